scc_mem_bridge: RTL and testbench

- Parametrised successor to the SCC core/memory wrapper.
- Sits between the SCC core's split instruction/data interfaces and a single-ported unified memory with a ready handshake.
- Arbitrates fetch and data accesses, holds the core stalled until each access completes, and aborts hung accesses via a timeout.

---
 rtl/scc_mem_bridge.sv | 199 +++++++++++++++++++
 tb/tb_scc_mem_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_mem_bridge.sv
// SCC core/memory bridge: arbitrates split fetch/data requests onto one ready-handshake memory port.
// Optional one-entry fetch buffer enabled by defining SCC_BRIDGE_IBUF_EN.
module scc_mem_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] scc_in_mem_addr,
  input  logic          scc_in_mem_en,
  output logic [DW-1:0] scc_in_mem,
  output logic          scc_in_valid,
  input  logic [AW-1:0] scc_data_addr,
  input  logic [DW-1:0] scc_data_out,
  input  logic          scc_data_read,
  input  logic          scc_data_write,
  output logic [DW-1:0] scc_data_in,
  output logic          scc_data_valid,
  output logic          scc_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_is_data;
  logic          r_is_write;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [DW-1:0] r_in_mem;
  logic          r_in_valid;
  logic [DW-1:0] r_data_in;
  logic          r_data_valid;
  logic          r_bus_error;

  logic          w_data_req;
  logic          w_timeout;
  logic          w_done;
  logic [DW-1:0] w_resp_word;
  logic          w_ib_hit;
  logic [DW-1:0] w_ib_word;

  assign w_data_req = scc_data_read | scc_data_write;

`ifdef SCC_BRIDGE_IBUF_EN
  logic          r_ib_valid;
  logic [AW-1:0] r_ib_tag;
  logic [DW-1:0] r_ib_word;

  assign w_ib_hit  = r_ib_valid && (r_ib_tag == scc_in_mem_addr);
  assign w_ib_word = r_ib_word;

  // Fill on a completed fetch; drop the entry when a data write lands on its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ib_valid <= 1'b0;
      r_ib_tag   <= '0;
      r_ib_word  <= '0;
    end else if (w_done) begin
      if (!r_is_data && mem_ready) begin
        r_ib_valid <= 1'b1;
        r_ib_tag   <= r_mem_addr;
        r_ib_word  <= mem_rdata;
      end else if (r_is_write && (r_mem_addr == r_ib_tag)) begin
        r_ib_valid <= 1'b0;
      end
    end
  end
`else
  assign w_ib_hit  = 1'b0;
  assign w_ib_word = '0;
`endif

  // Completion and timeout decode for the ACCESS state.
  always_comb begin
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    w_resp_word = '0;
    if (r_state == S_ACCESS) begin
      w_timeout = (TIMEOUT != 0) && !mem_ready && (r_cnt == TO_LAST);
      w_done    = mem_ready || w_timeout;
    end
    if (mem_ready && !r_is_write)
      w_resp_word = mem_rdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_data_req || (scc_in_mem_en && !w_ib_hit))
          w_state_nxt = S_ACCESS;
        else if (scc_in_mem_en)
          w_state_nxt = S_RESP;
      end
      S_ACCESS: if (w_done) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request latch, memory strobes and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_data    <= 1'b0;
      r_is_write   <= 1'b0;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_in_mem     <= '0;
      r_in_valid   <= 1'b0;
      r_data_in    <= '0;
      r_data_valid <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_in_valid   <= 1'b0;
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_data_req) begin
            r_is_data   <= 1'b1;
            r_is_write  <= scc_data_write;
            r_mem_addr  <= scc_data_addr;
            r_mem_wdata <= scc_data_write ? scc_data_out : '0;
            r_mem_read  <= !scc_data_write;
            r_mem_write <= scc_data_write;
            r_cnt       <= '0;
          end else if (scc_in_mem_en) begin
            r_is_data  <= 1'b0;
            r_is_write <= 1'b0;
            if (w_ib_hit) begin
              r_in_valid <= 1'b1;
              r_in_mem   <= w_ib_word;
            end else begin
              r_mem_addr  <= scc_in_mem_addr;
              r_mem_wdata <= '0;
              r_mem_read  <= 1'b1;
              r_cnt       <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_is_data) begin
              r_data_valid <= 1'b1;
              r_data_in    <= w_resp_word;
            end else begin
              r_in_valid <= 1'b1;
              r_in_mem   <= w_resp_word;
            end
            if (w_timeout) r_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign scc_in_mem     = r_in_mem;
  assign scc_in_valid   = r_in_valid;
  assign scc_data_in    = r_data_in;
  assign scc_data_valid = r_data_valid;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign bus_error      = r_bus_error;

  // Stall is combinational so the core freezes in the same cycle it raises a request.
  assign scc_stall = (scc_in_mem_en & ~r_in_valid) | (w_data_req & ~r_data_valid);

endmodule

// File: tb/tb_scc_mem_bridge.sv
// Directed bench for scc_mem_bridge with a latency-programmable memory model.
module tb_scc_mem_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] scc_in_mem_addr = '0;
  logic          scc_in_mem_en = 1'b0;
  logic [DW-1:0] scc_in_mem;
  logic          scc_in_valid;
  logic [AW-1:0] scc_data_addr = '0;
  logic [DW-1:0] scc_data_out = '0;
  logic          scc_data_read = 1'b0;
  logic          scc_data_write = 1'b0;
  logic [DW-1:0] scc_data_in;
  logic          scc_data_valid;
  logic          scc_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          bus_error;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  bit hang = 1'b0;
  int mcnt = 0;
  int n_rd = 0;
  int n_wr = 0;
  bit prev_rd = 1'b0;
  bit prev_wr = 1'b0;

  scc_mem_bridge #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .scc_in_mem_addr(scc_in_mem_addr), .scc_in_mem_en(scc_in_mem_en),
    .scc_in_mem(scc_in_mem), .scc_in_valid(scc_in_valid),
    .scc_data_addr(scc_data_addr), .scc_data_out(scc_data_out),
    .scc_data_read(scc_data_read), .scc_data_write(scc_data_write),
    .scc_data_in(scc_data_in), .scc_data_valid(scc_data_valid),
    .scc_stall(scc_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A0_1005;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: ready after 'lat' strobe cycles, never when 'hang'; counts access starts.
  always @(posedge clk) begin
    #1;
    if (mem_read && !prev_rd) n_rd++;
    if (mem_write && !prev_wr) n_wr++;
    prev_rd = mem_read;
    prev_wr = mem_write;
    if (!hang && (mem_read || mem_write)) begin
      if (mcnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read ? memval(mem_addr) : 32'hDEAD_BEEF;
        mcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    step();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", mem_read, mem_write); end
    checks++; if (scc_in_valid !== 1'b0 || scc_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", scc_in_valid, scc_data_valid); end
    checks++; if (bus_error !== 1'b0 || scc_stall !== 1'b0) begin failures++; $display("FAIL reset_err_stall got=%b%b exp=00", bus_error, scc_stall); end
    checks++; if (mem_addr !== 32'h0 || scc_in_mem !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0", mem_addr, scc_in_mem); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    int rd0;
    lat = 1; hang = 1'b0; rd0 = n_rd;
    scc_in_mem_addr = 32'h10; scc_in_mem_en = 1'b1;
    #1;
    checks++; if (scc_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0 got=%b exp=1", scc_stall); end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) begin
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h10) begin failures++; $display("FAIL fetch_strobe got=%b/%h exp=1/00000010", mem_read, mem_addr); end
      end
      if (c < 3) begin
        checks++; if (scc_in_valid !== 1'b0 || scc_stall !== 1'b1) begin failures++; $display("FAIL fetch_wait_c%0d got=%b%b exp=01", c, scc_in_valid, scc_stall); end
      end else begin
        checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'hE3A0_1005) begin failures++; $display("FAIL fetch_valid got=%b/%h exp=1/e3a01005", scc_in_valid, scc_in_mem); end
        checks++; if (scc_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall_done got=%b exp=0", scc_stall); end
      end
    end
    scc_in_mem_en = 1'b0;
    step();
    checks++; if (scc_in_valid !== 1'b0 || mem_read !== 1'b0 || (n_rd - rd0) != 1) begin failures++; $display("FAIL fetch_after got=%b%b reads=%0d exp=00 reads=1", scc_in_valid, mem_read, n_rd - rd0); end
  endtask

  task automatic test_arbitration();
    lat = 0; hang = 1'b0;
    scc_in_mem_addr = 32'h20; scc_in_mem_en = 1'b1;
    scc_data_addr = 32'h100; scc_data_read = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c < 5) begin
        checks++; if (scc_stall !== 1'b1) begin failures++; $display("FAIL arb_stall_c%0d got=%b exp=1", c, scc_stall); end
      end
      case (c)
        1: begin checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL arb_data_first got=%b/%h exp=1/00000100", mem_read, mem_addr); end end
        2: begin
          checks++; if (scc_data_valid !== 1'b1 || scc_data_in !== 32'h5A5A_0100 || scc_in_valid !== 1'b0) begin failures++; $display("FAIL arb_data_resp got=%b/%h/%b exp=1/5a5a0100/0", scc_data_valid, scc_data_in, scc_in_valid); end
          scc_data_read = 1'b0;
        end
        3: begin checks++; if (mem_read !== 1'b0 || scc_data_valid !== 1'b0) begin failures++; $display("FAIL arb_gap got=%b%b exp=00", mem_read, scc_data_valid); end end
        4: begin checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h20) begin failures++; $display("FAIL arb_fetch_second got=%b/%h exp=1/00000020", mem_read, mem_addr); end end
        default: begin
          checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'h5A5A_0020 || scc_stall !== 1'b0) begin failures++; $display("FAIL arb_fetch_resp got=%b/%h/%b exp=1/5a5a0020/0", scc_in_valid, scc_in_mem, scc_stall); end
          scc_in_mem_en = 1'b0;
        end
      endcase
    end
    step();
  endtask

  task automatic test_write_with_read();
    int rd0, wr0, nval;
    lat = 1; hang = 1'b0; rd0 = n_rd; wr0 = n_wr; nval = 0;
    scc_data_addr = 32'h200; scc_data_out = 32'hCAFE_F00D;
    scc_data_read = 1'b1; scc_data_write = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (scc_data_valid === 1'b1) nval++;
      if (c == 1) begin
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h200) begin failures++; $display("FAIL wr_strobe got=w%b r%b %h@%h exp=w1 r0 cafef00d@00000200", mem_write, mem_read, mem_wdata, mem_addr); end
      end
      if (c == 3) begin
        checks++; if (scc_data_valid !== 1'b1 || scc_data_in !== 32'h0) begin failures++; $display("FAIL wr_resp got=%b/%h exp=1/00000000", scc_data_valid, scc_data_in); end
        scc_data_read = 1'b0; scc_data_write = 1'b0;
      end
    end
    checks++; if (nval != 1 || (n_wr - wr0) != 1 || (n_rd - rd0) != 0) begin failures++; $display("FAIL wr_counts got=valid%0d wr%0d rd%0d exp=valid1 wr1 rd0", nval, n_wr - wr0, n_rd - rd0); end
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    scc_data_addr = 32'h300; scc_data_read = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (mem_read !== 1'b1 || bus_error !== 1'b0) begin failures++; $display("FAIL to_access_c%0d got=%b%b exp=10", c, mem_read, bus_error); end
    end
    step();
    checks++; if (mem_read !== 1'b0 || scc_data_valid !== 1'b1 || scc_data_in !== 32'h0 || bus_error !== 1'b1) begin failures++; $display("FAIL to_resp got=rd%b v%b %h err%b exp=rd0 v1 00000000 err1", mem_read, scc_data_valid, scc_data_in, bus_error); end
    scc_data_read = 1'b0; hang = 1'b0; lat = 0;
    step();
    checks++; if (scc_data_valid !== 1'b0 || bus_error !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b%b exp=01", scc_data_valid, bus_error); end
    scc_in_mem_addr = 32'h60; scc_in_mem_en = 1'b1;
    step(); step();
    checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'h5A5A_0060 || bus_error !== 1'b1) begin failures++; $display("FAIL to_after got=%b/%h/%b exp=1/5a5a0060/1", scc_in_valid, scc_in_mem, bus_error); end
    scc_in_mem_en = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int nval;
    hang = 1'b1; nval = 0;
    scc_data_addr = 32'h400; scc_data_read = 1'b1;
    step(); step();
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL abort_pre got=%b exp=1", mem_read); end
    #1 reset = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || bus_error !== 1'b0 || scc_data_valid !== 1'b0) begin failures++; $display("FAIL abort_async got=rd%b err%b v%b exp=000", mem_read, bus_error, scc_data_valid); end
    scc_data_read = 1'b0;
    step();
    reset = 1'b1; hang = 1'b0; lat = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (scc_data_valid === 1'b1 || scc_in_valid === 1'b1 || mem_read === 1'b1) nval++;
    end
    checks++; if (nval != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", nval); end
    scc_in_mem_addr = 32'h50; scc_in_mem_en = 1'b1;
    step();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h50) begin failures++; $display("FAIL abort_idle got=%b/%h exp=1/00000050", mem_read, mem_addr); end
    step();
    checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'h5A5A_0050) begin failures++; $display("FAIL abort_fetch got=%b/%h exp=1/5a5a0050", scc_in_valid, scc_in_mem); end
    scc_in_mem_en = 1'b0;
    step();
  endtask

  task automatic test_ibuf();
    int rd1;
    lat = 0; hang = 1'b0;
    scc_in_mem_addr = 32'h40; scc_in_mem_en = 1'b1;
    step(); step();
    checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'h5A5A_0040) begin failures++; $display("FAIL ib_first got=%b/%h exp=1/5a5a0040", scc_in_valid, scc_in_mem); end
    scc_in_mem_en = 1'b0;
    step();
    rd1 = n_rd;
    scc_in_mem_en = 1'b1;
    step();
`ifdef SCC_BRIDGE_IBUF_EN
    checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'h5A5A_0040 || mem_read !== 1'b0) begin failures++; $display("FAIL ib_hit got=v%b %h rd%b exp=v1 5a5a0040 rd0", scc_in_valid, scc_in_mem, mem_read); end
    scc_in_mem_en = 1'b0;
    step();
    checks++; if (n_rd != rd1) begin failures++; $display("FAIL ib_no_mem got=%0d exp=%0d", n_rd, rd1); end
    scc_data_addr = 32'h40; scc_data_out = 32'h1234_5678; scc_data_write = 1'b1;
    step(); step();
    scc_data_write = 1'b0;
    step();
    scc_in_mem_en = 1'b1;
    step();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h40 || scc_in_valid !== 1'b0) begin failures++; $display("FAIL ib_invalidated got=rd%b %h v%b exp=rd1 00000040 v0", mem_read, mem_addr, scc_in_valid); end
    step();
`else
    checks++; if (mem_read !== 1'b1 || scc_in_valid !== 1'b0) begin failures++; $display("FAIL ib_off_mem got=rd%b v%b exp=rd1 v0", mem_read, scc_in_valid); end
    step();
`endif
    checks++; if (scc_in_valid !== 1'b1 || scc_in_mem !== 32'h5A5A_0040) begin failures++; $display("FAIL ib_refetch got=%b/%h exp=1/5a5a0040", scc_in_valid, scc_in_mem); end
    scc_in_mem_en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_write_with_read();
    test_timeout();
    test_abort();
    test_ibuf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
